cflog_write_buffer: RTL and testbench
=====================================

// Module: cflog_write_buffer
// PURPOSE
//  Consumes log-monitor output (hw_wr_en, cflow_log_ptr, pc_nxt) and commits each CFLog entry to log RAM.
//  Decouples single-cycle write strobes from a req/ack memory port through a small FIFO.
//  Reports overflow and out-of-range drops, and acknowledges flush requests once all entries are committed.
// PARAMETERS
//  FIFO_DEPTH  4        entries buffered; power of two, >= 2
//  LOG_BASE    16'h0000 byte address of CFLog slot 0 in RAM
//  LOG_SIZE    16'h0100 log size in bytes; ptr >= LOG_SIZE is out of range
// PORTS
//  clk            in   1   system clock; all state on posedge
//  reset_n        in   1   asynchronous, active-low reset
//  hw_wr_en       in   1   log-monitor write strobe, one entry per high cycle
//  cflow_log_ptr  in   16  byte offset of entry (even)
//  pc_nxt         in   16  branch destination = entry data
//  flush          in   1   log-monitor flush request (level)
//  mem_req        out  1   RAM write request
//  mem_addr       out  16  RAM byte address
//  mem_wdata      out  16  RAM write data
//  mem_ack        in   1   RAM accepted write this cycle
//  fifo_full      out  1   FIFO count == FIFO_DEPTH
//  overflow       out  1   sticky: an entry was dropped because FIFO was full
//  oob            out  1   sticky: an entry was dropped because ptr >= LOG_SIZE
//  flush_done     out  1   one-cycle pulse: flush drained
//  idle           out  1   FIFO empty, no request pending
// BEHAVIOUR
//  Reset: all outputs 0, except idle = 1; FIFO count = 0; FSM = IDLE; stickies cleared. Async assert, sync release.
//  Push: on posedge with hw_wr_en = 1, {cflow_log_ptr, pc_nxt} is written to the FIFO tail.
//   - ptr >= LOG_SIZE: entry dropped, oob <= 1.
//   - FIFO full and no pop this cycle: entry dropped, overflow <= 1.
//   - FIFO full with pop this cycle (mem_req & mem_ack): push accepted; count unchanged.
//  Writer FSM states:
//   - IDLE: if count != 0, load head into mem_addr/mem_wdata; mem_req <= 1; go to REQ.
//   - REQ: mem_req, mem_addr and mem_wdata stay stable until mem_ack.
//     On mem_ack: pop the head. If another entry remains (count after pop and push != 0),
//     load it and keep mem_req = 1 (back-to-back). Otherwise mem_req <= 0 and go to IDLE.
//  Address arithmetic: mem_addr = LOG_BASE + ptr, 16-bit modulo; ptr[0] is forced to 0.
//  Latency: hw_wr_en at cycle N with the FIFO empty and FSM IDLE -> mem_req = 1 at cycle N+2.
//   (N+1: entry visible in FIFO; N+2: request registered.)
//  Throughput: one entry per cycle while mem_ack is held high.
//  Flush:
//   - Rising edge of flush sets flush_pend.
//   - Entries pushed while flush_pend is set are still accepted and committed.
//   - When flush_pend = 1, count = 0 and mem_req = 0: flush_done pulses for 1 cycle, flush_pend clears.
//   - Flush held high does not re-trigger; flush with the buffer already idle -> flush_done on the next cycle.
//   - The overflow and oob stickies clear on the flush_done cycle.
//  Ordering: entries are committed strictly in push order; no entry is written twice.
//  Reset mid-operation: a pending request is abandoned and FIFO contents are lost; the RAM may hold a partial log.
//  fifo_full and idle are combinational from registered state. mem_* outputs are registered.
// TESTING
//  1. Reset, then a single push (ptr=0x0004, pc_nxt=0xE0A2), mem_ack tied 1
//     -> mem_req high 2 cycles later with addr=LOG_BASE+4, data=0xE0A2, for exactly 1 cycle; idle returns to 1.
//  2. 6 consecutive pushes, FIFO_DEPTH=4, mem_ack=0 -> first 4 entries buffered, overflow=1, fifo_full=1.
//     Then release ack -> exactly 4 writes, in order, with the pushed addresses.
//  3. Push with ptr=0x0100 (==LOG_SIZE) -> no write, oob=1; a following push with ptr=0x00FE is written normally.
//  4. mem_ack held 1 during a burst of 8 pushes, one per cycle -> 8 back-to-back writes, mem_req never drops between them.
//  5. 3 entries pending, flush pulses, ack delayed 3 cycles per write -> flush_done pulses once, 1 cycle after the 3rd ack.
//     Stickies cleared. Repeat with the FIFO empty -> flush_done next cycle.
//  6. reset_n asserted while mem_req=1 -> mem_req=0 immediately (async); after release idle=1 and no stale write appears.

Source files
------------

// File: rtl/cflog_write_buffer.sv
// CFLog write buffer: queues log-monitor entries in a small FIFO and commits them
// to log RAM through a req/ack write port, with drop reporting and flush handshake.
module cflog_write_buffer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] LOG_BASE   = 16'h0000,
  parameter logic [15:0] LOG_SIZE   = 16'h0100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hw_wr_en,
  input  logic [15:0] cflow_log_ptr,
  input  logic [15:0] pc_nxt,
  input  logic        flush,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  output logic        fifo_full,
  output logic        overflow,
  output logic        oob,
  output logic        flush_done,
  output logic        idle
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {S_IDLE, S_REQ} state_t;

  // Reset: asserts asynchronously, releases on the second clock edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  state_t         state, state_nxt;
  logic [15:0]    fifo_addr [FIFO_DEPTH];
  logic [15:0]    fifo_data [FIFO_DEPTH];
  logic [AW-1:0]  rd_ptr, wr_ptr, rd_next;
  logic [CW-1:0]  count, count_nxt;
  logic           flush_q, flush_pend;

  logic           pop_c, push_c, in_range_c, drop_oob_c, drop_ovf_c;
  logic           flush_rise_c, done_c, req_nxt, load_c;
  logic [15:0]    push_addr_c, ld_addr_c, ld_data_c;

  assign fifo_full    = (count == CW'(FIFO_DEPTH));
  assign idle         = (count == '0) && !mem_req;

  assign pop_c        = mem_req & mem_ack;
  assign in_range_c   = (cflow_log_ptr < LOG_SIZE);
  assign push_c       = hw_wr_en & in_range_c & (!fifo_full | pop_c);
  assign drop_oob_c   = hw_wr_en & !in_range_c;
  assign drop_ovf_c   = hw_wr_en & in_range_c & fifo_full & !pop_c;
  assign push_addr_c  = LOG_BASE + {cflow_log_ptr[15:1], 1'b0};
  assign count_nxt    = count + CW'(push_c) - CW'(pop_c);
  assign rd_next      = rd_ptr + AW'(1);
  assign flush_rise_c = flush & !flush_q;

  // Writer next-state; on a back-to-back ack the next entry is either the
  // second FIFO slot or, with a single entry left, the entry being pushed now.
  always_comb begin
    state_nxt = state;
    req_nxt   = mem_req;
    load_c    = 1'b0;
    ld_addr_c = fifo_addr[rd_ptr];
    ld_data_c = fifo_data[rd_ptr];
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          load_c    = 1'b1;
          req_nxt   = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          if (count_nxt != '0) begin
            load_c  = 1'b1;
            req_nxt = 1'b1;
            if (count > CW'(1)) begin
              ld_addr_c = fifo_addr[rd_next];
              ld_data_c = fifo_data[rd_next];
            end else begin
              ld_addr_c = push_addr_c;
              ld_data_c = pc_nxt;
            end
          end else begin
            req_nxt   = 1'b0;
            state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        req_nxt   = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Flush completes when the buffer will be empty with no request next cycle.
  assign done_c = (flush_pend | flush_rise_c) & (count_nxt == '0) & !req_nxt;

  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_addr[wr_ptr] <= push_addr_c;
      fifo_data[wr_ptr] <= pc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      flush_q    <= 1'b0;
      flush_pend <= 1'b0;
      flush_done <= 1'b0;
      overflow   <= 1'b0;
      oob        <= 1'b0;
    end else begin
      state   <= state_nxt;
      mem_req <= req_nxt;
      if (load_c) begin
        mem_addr  <= ld_addr_c;
        mem_wdata <= ld_data_c;
      end
      if (pop_c)  rd_ptr <= rd_next;
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      count      <= count_nxt;
      flush_q    <= flush;
      flush_pend <= (flush_pend | flush_rise_c) & !done_c;
      flush_done <= done_c;
      // A drop in the same cycle as flush completion stays reported.
      if (drop_ovf_c)  overflow <= 1'b1;
      else if (done_c) overflow <= 1'b0;
      if (drop_oob_c)  oob <= 1'b1;
      else if (done_c) oob <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cflog_write_buffer.sv
// Bench for cflog_write_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_cflog_write_buffer;

  localparam int unsigned DEPTH    = 4;
  localparam logic [15:0] LOG_BASE = 16'h0000;
  localparam logic [15:0] LOG_SIZE = 16'h0100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        hw_wr_en;
  logic [15:0] cflow_log_ptr;
  logic [15:0] pc_nxt;
  logic        flush;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic        fifo_full;
  logic        overflow;
  logic        oob;
  logic        flush_done;
  logic        idle;

  cflog_write_buffer #(
    .FIFO_DEPTH(DEPTH),
    .LOG_BASE  (LOG_BASE),
    .LOG_SIZE  (LOG_SIZE)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .hw_wr_en     (hw_wr_en),
    .cflow_log_ptr(cflow_log_ptr),
    .pc_nxt       (pc_nxt),
    .flush        (flush),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .fifo_full    (fifo_full),
    .overflow     (overflow),
    .oob          (oob),
    .flush_done   (flush_done),
    .idle         (idle)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of accepted entries; the head is the entry on the port.
  logic [31:0] mq [$];
  bit req_m, pend_m, ovf_m, oob_m, done_m, flush_prev_m;

  task automatic model_clear();
    mq.delete();
    req_m = 0; pend_m = 0; ovf_m = 0; oob_m = 0; done_m = 0; flush_prev_m = 0;
  endtask

  task automatic model_step();
    bit rise, pop, inr, acc, dovf, doob, nreq, done;
    int unsigned sz;
    logic [31:0] tmp;
    logic [15:0] a;
    rise = flush && !flush_prev_m;
    flush_prev_m = flush;
    pop  = req_m && mem_ack;
    inr  = cflow_log_ptr < LOG_SIZE;
    sz   = mq.size();
    acc  = hw_wr_en && inr && (sz < DEPTH || pop);
    dovf = hw_wr_en && inr && !acc;
    doob = hw_wr_en && !inr;
    if (pop) tmp = mq.pop_front();
    if (acc) begin
      a = LOG_BASE + (cflow_log_ptr & 16'hFFFE);
      mq.push_back({a, pc_nxt});
    end
    nreq   = req_m ? (pop ? (mq.size() != 0) : 1'b1) : (sz != 0);
    req_m  = nreq;
    done   = (pend_m || rise) && mq.size() == 0 && !nreq;
    pend_m = (pend_m || rise) && !done;
    ovf_m  = dovf ? 1'b1 : (done ? 1'b0 : ovf_m);
    oob_m  = doob ? 1'b1 : (done ? 1'b0 : oob_m);
    done_m = done;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_clear();
      else          model_step();
    end
  end

  // Per-cycle compare plus commit/flush observation for the directed checks.
  logic [31:0] commits [$];
  int last_commit_cyc = 0, done_cyc = 0, done_cnt = 0, req_run = 0, max_run = 0;

  initial begin
    #15;
    forever begin
      @(negedge clk);
      check("mem_req", 32'(mem_req), 32'(req_m));
      if (req_m && mq.size() != 0) begin
        check("mem_addr",  32'(mem_addr),  32'(mq[0][31:16]));
        check("mem_wdata", 32'(mem_wdata), 32'(mq[0][15:0]));
      end
      check("fifo_full",  32'(fifo_full),  32'(mq.size() == DEPTH));
      check("idle",       32'(idle),       32'(mq.size() == 0 && !req_m));
      check("overflow",   32'(overflow),   32'(ovf_m));
      check("oob",        32'(oob),        32'(oob_m));
      check("flush_done", 32'(flush_done), 32'(done_m));
      if (mem_req && mem_ack) begin
        commits.push_back({mem_addr, mem_wdata});
        last_commit_cyc = cyc;
      end
      if (flush_done) begin
        done_cyc = cyc;
        done_cnt++;
      end
      if (mem_req) begin
        req_run++;
        if (req_run > max_run) max_run = req_run;
      end else begin
        req_run = 0;
      end
    end
  end

  // Slow RAM: ack raised on the third cycle of each request.
  bit ack_delay = 0;
  int ack_wait  = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ack_delay) begin
        if (mem_req && !mem_ack) begin
          ack_wait++;
          if (ack_wait == 3) mem_ack = 1'b1;
        end else begin
          mem_ack  = 1'b0;
          ack_wait = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] p, input logic [15:0] d);
    hw_wr_en = 1'b1; cflow_log_ptr = p; pc_nxt = d;
    tick();
    hw_wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int k = 0;
    while (!idle && k < max_cyc) begin
      tick();
      k++;
    end
    check(name, 32'(idle), 32'd1);
    tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset_n = 1'b0; hw_wr_en = 1'b0; cflow_log_ptr = '0; pc_nxt = '0;
    flush = 1'b0; mem_ack = 1'b0;
    do_reset();

    // Reset state
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_idle",    32'(idle),    32'd1);

    // 1: single push, ack tied high, request two cycles after the strobe
    mem_ack = 1'b1;
    push(16'h0004, 16'hE0A2);
    tick();
    check("t1_req",  32'(mem_req),   32'd1);
    check("t1_addr", 32'(mem_addr),  32'h0004);
    check("t1_data", 32'(mem_wdata), 32'hE0A2);
    tick();
    check("t1_req_drop", 32'(mem_req), 32'd0);
    check("t1_idle",     32'(idle),    32'd1);

    // 2: six pushes into a stalled RAM, then drain four in order
    mem_ack = 1'b0;
    commits.delete();
    for (int i = 0; i < 6; i++) push(16'h0010 + 16'(2 * i), 16'hA000 + 16'(i));
    check("t2_overflow", 32'(overflow),  32'd1);
    check("t2_full",     32'(fifo_full), 32'd1);
    mem_ack = 1'b1;
    wait_idle("t2_drain_timeout", 50);
    check("t2_ncommit", 32'(commits.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < commits.size())
        check("t2_commit", commits[i], {16'h0010 + 16'(2 * i), 16'hA000 + 16'(i)});

    // 3: out-of-range pointer dropped, last in-range slot written
    commits.delete();
    push(16'h0100, 16'h1111);
    push(16'h00FE, 16'h2222);
    wait_idle("t3_drain_timeout", 50);
    check("t3_oob",     32'(oob),             32'd1);
    check("t3_ncommit", 32'(commits.size()),  32'd1);
    if (commits.size() != 0) check("t3_commit", commits[0], 32'h00FE_2222);

    // 4: eight-entry burst with ack held, one write per cycle
    commits.delete();
    max_run = 0;
    for (int i = 0; i < 8; i++)
      push(16'h0020 + 16'(2 * i) + ((i == 0) ? 16'h0001 : 16'h0000), 16'hB000 + 16'(i));
    wait_idle("t4_drain_timeout", 50);
    check("t4_ncommit", 32'(commits.size()), 32'd8);
    check("t4_req_run", 32'(max_run),        32'd8);
    if (commits.size() == 8) begin
      check("t4_first", commits[0], 32'h0020_B000);
      check("t4_last",  commits[7], 32'h002E_B007);
    end

    // 5: flush with three entries pending and a slow RAM
    check("t5_ovf_before", 32'(overflow), 32'd1);
    check("t5_oob_before", 32'(oob),      32'd1);
    commits.delete();
    done_cnt = 0;
    mem_ack = 1'b0;
    ack_delay = 1;
    push(16'h0040, 16'hC000);
    push(16'h0042, 16'hC001);
    push(16'h0044, 16'hC002);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    k = 0;
    while (done_cnt == 0 && k < 100) begin
      tick();
      k++;
    end
    repeat (4) tick();
    ack_delay = 0;
    mem_ack = 1'b1;
    check("t5_done_cnt", 32'(done_cnt),        32'd1);
    check("t5_ncommit",  32'(commits.size()),  32'd3);
    check("t5_done_lat", 32'(done_cyc),        32'(last_commit_cyc + 1));
    check("t5_ovf_clr",  32'(overflow),        32'd0);
    check("t5_oob_clr",  32'(oob),             32'd0);

    // 5b: flush with the buffer already empty, held high for several cycles
    done_cnt = 0;
    k = cyc;
    flush = 1'b1;
    repeat (4) tick();
    flush = 1'b0;
    repeat (3) tick();
    check("t5b_done_cnt", 32'(done_cnt), 32'd1);
    check("t5b_done_lat", 32'(done_cyc), 32'(k + 1));

    // 6: reset while a request is outstanding
    mem_ack = 1'b0;
    push(16'h0050, 16'h5555);
    k = 0;
    while (!mem_req && k < 10) begin
      tick();
      k++;
    end
    check("t6_req_before", 32'(mem_req), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_req_async", 32'(mem_req), 32'd0);
    commits.delete();
    repeat (3) tick();
    reset_n = 1'b1;
    mem_ack = 1'b1;
    repeat (6) tick();
    check("t6_idle",    32'(idle),            32'd1);
    check("t6_no_stale", 32'(commits.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
